// File: rtl/traffic_pkg.sv
// traffic_pkg: shared road-grant types, constants and helpers
package traffic_pkg;
  localparam int NUM_ROADS = 4;
  typedef enum logic [1:0] {IDLE, GREEN, AMBER, CLEAR} state_t;
  function automatic logic is_onehot(input logic [NUM_ROADS-1:0] v);
    return $countones(v) == 1;
  endfunction
endpackage

// File: rtl/traffic_lamp_driver_phase_timer.sv
// phase_timer: loadable down-counter that saturates at zero and flags done there
module phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign done = cnt == '0;
endmodule

// File: rtl/traffic_lamp_driver.sv
// traffic_lamp_driver: turns one-hot road grants into safe green/amber/all-red lamp sequences
module traffic_lamp_driver
  import traffic_pkg::*;
#(
  parameter int AMBER_CYC  = 3,
  parameter int ALLRED_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_ROADS-1:0] traffic,
  output logic [NUM_ROADS-1:0] red,
  output logic [NUM_ROADS-1:0] amber,
  output logic [NUM_ROADS-1:0] green,
  output logic                 clear,
  output logic                 fault
);
  localparam int TW = $clog2(AMBER_CYC > ALLRED_CYC ? AMBER_CYC : ALLRED_CYC) + 1;
  state_t state, state_n;
  logic [NUM_ROADS-1:0] cur, cur_n, red_n, amber_n, green_n;
  logic load, done, valid, multi, clear_n;
  logic [TW-1:0] load_val;
  assign valid = is_onehot(traffic);
  assign multi = $countones(traffic) > 1;
  phase_timer #(.W(TW)) u_timer (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .done(done)
  );
  always_comb begin
    state_n  = state;
    cur_n    = cur;
    load     = 1'b0;
    load_val = TW'(AMBER_CYC - 1);
    case (state)
      IDLE: begin
        state_n = valid ? GREEN : IDLE;
        cur_n   = valid ? traffic : '0;
      end
      GREEN: begin
        state_n = traffic != cur ? AMBER : GREEN;
        load    = traffic != cur;
      end
      AMBER: begin
        state_n  = done ? CLEAR : AMBER;
        load     = done;
        load_val = TW'(ALLRED_CYC - 1);
      end
      CLEAR: begin
        state_n = !done ? CLEAR : valid ? GREEN : IDLE;
        cur_n   = !done ? cur : valid ? traffic : '0;
      end
      default: state_n = IDLE;
    endcase
    green_n = state_n == GREEN ? cur_n : '0;
    amber_n = state_n == AMBER ? cur_n : '0;
    red_n   = ~(green_n | amber_n);
    clear_n = state_n == IDLE || state_n == CLEAR;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cur   <= '0;
      red   <= '1;
      amber <= '0;
      green <= '0;
      clear <= 1'b1;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      cur   <= cur_n;
      red   <= red_n;
      amber <= amber_n;
      green <= green_n;
      clear <= clear_n;
      fault <= fault | multi;
    end
endmodule

// File: tb/tb_traffic_lamp_driver.sv
// tb_traffic_lamp_driver: directed grant sequences checked against a scoreboard of expected lamps
module tb_traffic_lamp_driver;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] traffic = 4'b0000;
  logic [3:0] red, amber, green;
  logic clear, fault;
  int checks = 0, failures = 0;
  logic [13:0] expq[$];
  traffic_lamp_driver dut (
    .clk(clk), .rst(rst), .traffic(traffic), .red(red), .amber(amber),
    .green(green), .clear(clear), .fault(fault)
  );
  always #5 clk = ~clk;
  function automatic logic [13:0] model(input byte ph, input logic [3:0] road, input logic f);
    logic [3:0] g, a;
    g = ph == "G" ? road : 4'b0000;
    a = ph == "A" ? road : 4'b0000;
    return {~(g | a), a, g, ph == "R", f};
  endfunction
  task automatic step(input logic r, input logic [3:0] tr, input byte ph, input logic [3:0] road, input logic f);
    @(negedge clk);
    rst = r;
    traffic = tr;
    expq.push_back(model(ph, road, f));
  endtask
  always @(posedge clk) begin
    #1;
    if (expq.size() > 0) begin
      logic [13:0] e;
      e = expq.pop_front();
      checks++;
      if ({red, amber, green, clear, fault} !== e) begin
        failures++;
        $display("FAIL lamps check %0d: got red=%b amber=%b green=%b clear=%b fault=%b want red=%b amber=%b green=%b clear=%b fault=%b",
                 checks, red, amber, green, clear, fault, e[13:10], e[9:6], e[5:2], e[1], e[0]);
      end
    end
  end
  task automatic handover(input logic [3:0] tr, input logic [3:0] from, input logic f);
    repeat (3) step(0, tr, "A", from, f);
    repeat (2) step(0, tr, "R", 4'b0000, f);
    step(0, tr, "G", tr, f);
  endtask
  initial begin
    step(1, 4'b0001, "R", 4'b0000, 0);
    step(1, 4'b0001, "R", 4'b0000, 0);
    repeat (5) step(0, 4'b0001, "G", 4'b0001, 0);
    handover(4'b0010, 4'b0001, 0);
    step(0, 4'b0010, "G", 4'b0010, 0);
    handover(4'b0100, 4'b0010, 0);
    repeat (3) step(0, 4'b0000, "A", 4'b0100, 0);
    repeat (2) step(0, 4'b0000, "R", 4'b0000, 0);
    repeat (2) step(0, 4'b0000, "R", 4'b0000, 0);
    step(0, 4'b1000, "G", 4'b1000, 0);
    handover(4'b0001, 4'b1000, 0);
    step(0, 4'b0100, "A", 4'b0001, 0);
    repeat (2) step(0, 4'b0001, "A", 4'b0001, 0);
    repeat (2) step(0, 4'b0001, "R", 4'b0000, 0);
    step(0, 4'b0001, "G", 4'b0001, 0);
    handover(4'b0010, 4'b0001, 0);
    step(0, 4'b0110, "A", 4'b0010, 1);
    repeat (2) step(0, 4'b0010, "A", 4'b0010, 1);
    repeat (2) step(0, 4'b0010, "R", 4'b0000, 1);
    repeat (2) step(0, 4'b0010, "G", 4'b0010, 1);
    repeat (2) step(0, 4'b0001, "A", 4'b0010, 1);
    step(1, 4'b0001, "R", 4'b0000, 0);
    repeat (2) step(0, 4'b0000, "R", 4'b0000, 0);
    for (int i = 0; i < 20 && expq.size() > 0; i++) @(negedge clk);
    if (expq.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries never compared, want 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/traffic_lamp_driver.md
Name: traffic_lamp_driver

Overview:
- Consumer end of the `traffic[4:1]` one-hot grant bus produced by the `traffic` controller.
- Converts each grant change into safe per-road lamp drives: green, then amber for a fixed interval, then all-red clearance, then green on the newly granted road.
- Sits between the controller and the lamp I/O; validates the grant bus and flags malformed grants.
- One clock cycle = 1 s, matching the controller's timebase.

Parameters:
- AMBER_CYC, 3, clock cycles amber is shown on a road losing green (must be >=1).
- ALLRED_CYC, 2, clock cycles all-red clearance after amber, before any new green (must be >=1).

Ports:
- clk  input  1  system clock (1 s period).
- rst  input  1  synchronous, active-high reset.
- traffic  input  4  grant from controller; bit k = road Tk granted; expected one-hot or zero.
- red  output  4  red lamp per road, bit k = Tk.
- amber  output  4  amber lamp per road.
- green  output  4  green lamp per road.
- clear  output  1  high while the block is in all-red (CLEAR or IDLE).
- fault  output  1  sticky: grant seen with more than one bit set.

Behaviour:
- All outputs are registered and decoded from state plus the current road register `cur`.
- Every road shows exactly one lamp every cycle. Road `cur` shows green or amber per state; all other roads show red.
- States:
  - IDLE: all red; no road owned.
  - GREEN: road `cur` green.
  - AMBER: road `cur` amber.
  - CLEAR: all red; timed clearance.
- Reset (rst high at an edge):
  - State = IDLE, `cur` = 0, timer = 0.
  - red = 4'b1111, amber = 0, green = 0, clear = 1, fault = 0.
  - Reset mid-sequence aborts immediately to this state; no amber is completed.
- Grant validity: valid when `traffic` is exactly one-hot. A zero or multi-hot grant is treated as "no grant".
- Transitions, sampled at each clk edge:
  - IDLE: valid grant g → GREEN with `cur` = g. Green becomes visible after that edge (1-cycle latency).
  - GREEN: if `traffic` != `cur` (another road, zero, or multi-hot) → AMBER, timer = AMBER_CYC-1. Otherwise hold green indefinitely.
  - AMBER: decrement timer. When timer = 0 → CLEAR, timer = ALLRED_CYC-1. Amber therefore lasts exactly AMBER_CYC cycles.
  - CLEAR: decrement timer. When timer = 0:
    - valid grant g → GREEN with `cur` = g;
    - otherwise → IDLE.
    - Clearance therefore lasts exactly ALLRED_CYC cycles.
- Grant changes during AMBER or CLEAR are ignored until CLEAR expires. This includes the grant returning to `cur`: the sequence is never aborted, and `cur` may be re-granted after clearance.
- Only the grant value present on the CLEAR-expiry edge matters; intermediate grants are not queued.
- fault:
  - Set on the edge after any multi-hot `traffic` is sampled, in any state.
  - Stays high until rst.
  - Zero grant does not set fault.
- Timer width: $clog2 of max(AMBER_CYC, ALLRED_CYC) plus 1 bit. Decrement never wraps; it is reloaded on state entry.
- Simultaneous rst and a grant change: rst wins.

Decomposition:
- Shared package `traffic_pkg`:
  - state encoding (IDLE, GREEN, AMBER, CLEAR);
  - road width constant NUM_ROADS = 4;
  - `is_onehot` function.
- The `traffic` controller reuses `NUM_ROADS` and `is_onehot`.
- One sub-module: `phase_timer`, a loadable down-counter with a `done` flag at zero, used for both the AMBER and CLEAR phases.

Test Plan:
- Reset: rst=1 for 2 cycles with traffic=4'b0001 → red=1111, green=0, clear=1, fault=0. Release → green=0001 one cycle later.
- Handover: hold traffic=0001 for 5 cycles, then 0010 → T1 amber for 3 cycles, all red for 2 cycles, then green=0010 and red=1101.
- Drop to zero: green on T3, then traffic=0 → 3 amber cycles, 2 clear cycles, IDLE (clear=1). Then traffic=1000 → green=1000 on the next edge.
- Re-grant during amber: T1 green, traffic=0100 for 1 cycle, then back to 0001 → full amber (3) plus clear (2) still executed, then green=0001.
- Multi-hot: T2 green, traffic=0110 → fault=1 next cycle and T2 goes amber. Fault stays 1 after traffic=0010 until rst.
- Reset mid-amber: rst during the 2nd amber cycle → next cycle red=1111, amber=0, clear=1, fault cleared.
